// File: rtl/master_link_ctrl_pkg.sv
// Shared definitions for the master end of the subnode serial link.
package master_link_ctrl_pkg;

  localparam int unsigned NB_DEF      = 4;
  localparam int unsigned NK_DEF      = 8;
  localparam int unsigned NR_DEF      = 14;
  localparam int unsigned TIMEOUT_DEF = 1024;

  localparam int unsigned MSG_W = 32 * NB_DEF;
  localparam int unsigned KEY_W = 32 * NK_DEF;

  // Link phases, shared with the subnode so both ends agree on the sequence
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND_MSG,
    S_SEND_KEY,
    S_WAIT,
    S_RECV,
    S_DONE
  } link_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/master_link_ctrl_link_shift_reg.sv
// Loadable MSB-first shift register; OUT_W selects how many top bits are exposed.
module link_shift_reg #(
  parameter int unsigned W     = 8,
  parameter int unsigned OUT_W = W
) (
  input  logic             in_clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_si,
  input  logic [W-1:0]     i_data,
  output logic [OUT_W-1:0] o_data
);

  logic [W-1:0] r_data;

  // Parallel load wins over shift; shift moves toward the MSB, new bit enters at LSB
  always_ff @(posedge in_clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_shift) begin
      r_data <= {r_data[W-2:0], i_si};
    end
  end

  assign o_data = r_data[W-1 -: OUT_W];

endmodule

// File: rtl/master_link_ctrl.sv
// Master side of the subnode link: sends message then key serially, collects the result.
module master_link_ctrl
  import master_link_ctrl_pkg::*;
#(
  parameter int unsigned nk      = NK_DEF,
  parameter int unsigned nb      = NB_DEF,
  parameter int unsigned nr      = NR_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              in_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [32*nb-1:0]  msg_in,
  input  logic [32*nk-1:0]  key_in,
  input  logic              sdo_link,
  input  logic              link_valid,
  output logic              cs,
  output logic              sdi_link,
  output logic [32*nb-1:0]  result,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned MW = 32 * nb;
  localparam int unsigned KW = 32 * nk;
  localparam int unsigned CW = $clog2(max_u(max_u(MW, KW), TIMEOUT) + 1);

  // Round count only rides along for interface parity with the subnode
  if (nr == 0) begin : g_nr_unused
  end

  link_state_e    r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_cs;
  logic           r_sdi;
  logic [MW-1:0]  r_result;
  logic           r_busy;
  logic           r_done;
  logic           r_error;

  link_state_e    w_state_n;
  logic [CW-1:0]  w_cnt_n;
  logic           w_cs_n;
  logic           w_sdi_n;
  logic [MW-1:0]  w_result_n;
  logic           w_busy_n;
  logic           w_done_n;
  logic           w_error_n;
  logic           w_load;
  logic           w_sh_msg;
  logic           w_sh_key;
  logic           w_sh_rx;
  logic           w_msg_msb;
  logic           w_key_msb;
  logic [MW-2:0]  w_rx_q;

  link_shift_reg #(.W(MW), .OUT_W(1)) u_msg_tx (
    .in_clk (in_clk),
    .rst    (rst),
    .i_load (w_load),
    .i_shift(w_sh_msg),
    .i_si   (1'b0),
    .i_data (msg_in),
    .o_data (w_msg_msb)
  );

  link_shift_reg #(.W(KW), .OUT_W(1)) u_key_tx (
    .in_clk (in_clk),
    .rst    (rst),
    .i_load (w_load),
    .i_shift(w_sh_key),
    .i_si   (1'b0),
    .i_data (key_in),
    .o_data (w_key_msb)
  );

  // Holds the first MW-1 received bits; the final bit is merged straight from the line
  link_shift_reg #(.W(MW - 1), .OUT_W(MW - 1)) u_res_rx (
    .in_clk (in_clk),
    .rst    (rst),
    .i_load (w_load),
    .i_shift(w_sh_rx),
    .i_si   (sdo_link),
    .i_data ('0),
    .o_data (w_rx_q)
  );

  // State, counter and registered outputs
  always_ff @(posedge in_clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_cs     <= 1'b1;
      r_sdi    <= 1'b0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_cs     <= w_cs_n;
      r_sdi    <= w_sdi_n;
      r_result <= w_result_n;
      r_busy   <= w_busy_n;
      r_done   <= w_done_n;
      r_error  <= w_error_n;
    end
  end

  // Next-state, counter and next output values
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_sdi_n    = 1'b0;
    w_result_n = r_result;
    w_done_n   = 1'b0;
    w_error_n  = 1'b0;
    w_load     = 1'b0;
    w_sh_msg   = 1'b0;
    w_sh_key   = 1'b0;
    w_sh_rx    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_n = S_LOAD;
          w_cnt_n   = '0;
          w_load    = 1'b1;
        end
      end
      S_LOAD: begin
        w_state_n = S_SEND_MSG;
        w_cnt_n   = '0;
        w_sdi_n   = w_msg_msb;
        w_sh_msg  = 1'b1;
      end
      S_SEND_MSG: begin
        if (r_cnt == CW'(MW - 1)) begin
          w_state_n = S_SEND_KEY;
          w_cnt_n   = '0;
          w_sdi_n   = w_key_msb;
          w_sh_key  = 1'b1;
        end else begin
          w_cnt_n   = r_cnt + CW'(1);
          w_sdi_n   = w_msg_msb;
          w_sh_msg  = 1'b1;
        end
      end
      S_SEND_KEY: begin
        if (r_cnt == CW'(KW - 1)) begin
          w_state_n = S_WAIT;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n   = r_cnt + CW'(1);
          w_sdi_n   = w_key_msb;
          w_sh_key  = 1'b1;
        end
      end
      S_WAIT: begin
        if (link_valid) begin
          w_state_n = S_RECV;
          w_cnt_n   = CW'(1);
          w_sh_rx   = 1'b1;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
          w_error_n = 1'b1;
        end else begin
          w_cnt_n   = r_cnt + CW'(1);
        end
      end
      S_RECV: begin
        if (link_valid) begin
          if (r_cnt == CW'(MW - 1)) begin
            w_state_n  = S_DONE;
            w_cnt_n    = '0;
            w_result_n = {w_rx_q, sdo_link};
            w_done_n   = 1'b1;
          end else begin
            w_cnt_n    = r_cnt + CW'(1);
            w_sh_rx    = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
      end
    endcase

    w_busy_n = (w_state_n != S_IDLE);
    w_cs_n   = (w_state_n == S_IDLE);
  end

  assign cs       = r_cs;
  assign sdi_link = r_sdi;
  assign result   = r_result;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;

endmodule
